// File: rtl/cache_ls_port_if.sv
// Bundles the CPU-side request/response handshake with the cache-side
// address/write_enable/busy/data_out_ready bus of the load/store port.
interface cache_ls_port_if;
  // Core-side request / response
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  // Cache-side bus
  logic [31:0] address;
  logic [31:0] data_in;
  logic [3:0]  write_enable;
  logic [31:0] data_out;
  logic        data_out_ready;
  logic        busy;

  // Environment view: drives requests and plays the cache.
  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output data_out, data_out_ready, busy,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  address, data_in, write_enable
  );

  // Load/store port view.
  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  data_out, data_out_ready, busy,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output address, data_in, write_enable
  );
endinterface

// File: rtl/cache_ls_port.sv
// Load/store initiator: turns one sized byte/half/word request into a word-aligned
// cache access with byte-lane mask, then returns extended read data in a one-cycle response.
module cache_ls_port #(
  parameter int unsigned TIMEOUT_CYCLES   = 1024,
  parameter int unsigned COUNTER_BITWIDTH = 11
) (
  input logic             clk,
  input logic             rst_n,
  cache_ls_port_if.slave  bus_io
);

  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StSettle,
    StWaitR,
    StWaitW,
    StResp
  } state_e;

  state_e                      state_q;
  logic                        write_q;
  logic [1:0]                  size_q;
  logic                        unsigned_q;
  logic [31:0]                 addr_q;
  logic [31:0]                 wdata_q;
  logic [COUNTER_BITWIDTH-1:0] cnt_q;
  logic [31:0]                 address_q;
  logic [31:0]                 data_in_q;
  logic [3:0]                  we_q;
  logic                        resp_valid_q;
  logic [31:0]                 resp_rdata_q;
  logic                        resp_error_q;

  logic                        req_bad;
  logic [1:0]                  lane;
  logic [4:0]                  lane_shift;
  logic [3:0]                  lane_mask;
  logic [31:0]                 lane_data;
  logic [31:0]                 rd_shifted;
  logic [31:0]                 rd_ext;
  logic                        timeout_hit;

  // Alignment / size legality is judged on the live request so errors skip the cache.
  always_comb begin
    req_bad = 1'b0;
    unique case (bus_io.req_size)
      2'd0:    req_bad = 1'b0;
      2'd1:    req_bad = bus_io.req_addr[0];
      2'd2:    req_bad = (bus_io.req_addr[1:0] != 2'b00);
      default: req_bad = 1'b1;
    endcase
  end

  assign lane       = addr_q[1:0];
  assign lane_shift = {lane, 3'b000};

  always_comb begin
    lane_mask = 4'b1111;
    lane_data = wdata_q;
    unique case (size_q)
      2'd0: begin
        lane_mask = 4'b0001 << lane;
        lane_data = {24'b0, wdata_q[7:0]} << lane_shift;
      end
      2'd1: begin
        lane_mask = 4'b0011 << lane;
        lane_data = {16'b0, wdata_q[15:0]} << lane_shift;
      end
      default: begin
        lane_mask = 4'b1111;
        lane_data = wdata_q;
      end
    endcase
  end

  always_comb begin
    rd_shifted = bus_io.data_out >> lane_shift;
    rd_ext     = rd_shifted;
    unique case (size_q)
      2'd0:    rd_ext = unsigned_q ? {24'b0, rd_shifted[7:0]}
                                   : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
      2'd1:    rd_ext = unsigned_q ? {16'b0, rd_shifted[15:0]}
                                   : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
      default: rd_ext = rd_shifted;
    endcase
  end

  // True on the cycle whose increment brings the counter to the limit.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      write_q      <= 1'b0;
      size_q       <= 2'd0;
      unsigned_q   <= 1'b0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      cnt_q        <= '0;
      address_q    <= 32'h0;
      data_in_q    <= 32'h0;
      we_q         <= 4'h0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= 32'h0;
      resp_error_q <= 1'b0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus_io.req_valid) begin
            write_q    <= bus_io.req_write;
            size_q     <= bus_io.req_size;
            unsigned_q <= bus_io.req_unsigned;
            addr_q     <= bus_io.req_addr;
            wdata_q    <= bus_io.req_wdata;
            cnt_q      <= '0;
            if (req_bad) begin
              resp_valid_q <= 1'b1;
              resp_error_q <= 1'b1;
              resp_rdata_q <= 32'h0;
              state_q      <= StResp;
            end else begin
              state_q <= StIssue;
            end
          end
        end
        StIssue: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            we_q         <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'h0;
            state_q      <= StResp;
          end else if (!bus_io.busy) begin
            address_q <= {addr_q[31:2], 2'b00};
            data_in_q <= lane_data;
            we_q      <= write_q ? lane_mask : 4'h0;
            state_q   <= StSettle;
          end
        end
        StSettle: begin
          // busy/data_out_ready still describe the previous access here.
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            we_q         <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'h0;
            state_q      <= StResp;
          end else begin
            state_q <= write_q ? StWaitW : StWaitR;
          end
        end
        StWaitR: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            we_q         <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'h0;
            state_q      <= StResp;
          end else if (bus_io.data_out_ready) begin
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= rd_ext;
            state_q      <= StResp;
          end
        end
        StWaitW: begin
          cnt_q <= cnt_q + 1'b1;
          if (timeout_hit) begin
            we_q         <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b1;
            resp_rdata_q <= 32'h0;
            state_q      <= StResp;
          end else if (!bus_io.busy) begin
            we_q         <= 4'h0;
            resp_valid_q <= 1'b1;
            resp_error_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            state_q      <= StResp;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          we_q    <= 4'h0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus_io.req_ready    = (state_q == StIdle);
  assign bus_io.resp_valid   = resp_valid_q;
  assign bus_io.resp_rdata   = resp_rdata_q;
  assign bus_io.resp_error   = resp_error_q;
  assign bus_io.address      = address_q;
  assign bus_io.data_in      = data_in_q;
  assign bus_io.write_enable = we_q;

endmodule

// File: doc/cache_ls_port.md
Name: cache_ls_port

Overview:
- Load/store initiator on the CPU side of the cache; the requester end of the cache's address/write_enable/busy/data_out_ready interface.
- Accepts one sized memory request at a time over a valid/ready front end.
- Converts byte/half/word accesses into a word-aligned cache address, a byte-lane write mask and lane-shifted write data.
- Extracts and sign/zero-extends read data, then returns a one-cycle response. Sits between the core's execute stage and the cache.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles spent in ISSUE+SETTLE+WAIT_* before an error response; 0 disables the timeout.
COUNTER_BITWIDTH, 11, width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request
req_write  in  1  0 load, 1 store
req_size  in  2  0 byte, 1 half, 2 word; 3 is illegal
req_unsigned  in  1  loads only: zero-extend when 1, sign-extend when 0
req_addr  in  32  byte address
req_wdata  in  32  store data, right-aligned
resp_valid  out  1  one-cycle response strobe
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  misaligned, illegal size or timeout; valid with resp_valid
address  out  32  to cache; word aligned, low 2 bits always 0
data_in  out  32  to cache; store data shifted to its byte lane
write_enable  out  4  to cache; byte-lane mask, 0 for reads
data_out  in  32  from cache
data_out_ready  in  1  from cache
busy  in  1  from cache

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; address=0, data_in=0, write_enable=0, resp_valid=0, resp_rdata=0, resp_error=0, counter=0.
- Reset mid-operation aborts the request immediately: write_enable drops to 0 and no response is issued.
- req_ready = (state==IDLE). Handshake completes when req_valid and req_ready are both high at a clock edge; the block latches all req_* fields.
- Alignment: half needs addr[0]=0; word needs addr[1:0]=0. Misaligned or size 3 -> go to RESP with resp_error=1. No cache signal changes.
- Lane mapping, with o=addr[1:0]:
  - byte: mask = 0001<<o; data_in = wdata[7:0]<<(8*o)
  - half: mask = 0011<<o; data_in = wdata[15:0]<<(8*o)
  - word: mask = 1111; data_in = wdata
- Read extraction: shift data_out right by 8*o, take the low 8/16/32 bits, then extend per req_unsigned. Word loads ignore req_unsigned.
- State machine (all outputs registered):
  - IDLE: accept request -> ISSUE, or -> RESP on error.
  - ISSUE: while busy=1, hold and keep write_enable=0. On busy=0, load address={addr[31:2],2'b0}, data_in and write_enable (mask for stores, 0 for loads) -> SETTLE.
  - SETTLE: exactly one cycle. Cache inputs are held and busy/data_out_ready are ignored, because they still reflect the previous access. -> WAIT_R for loads, -> WAIT_W for stores.
  - WAIT_R: hold all cache outputs. On data_out_ready=1, capture the extracted data -> RESP.
  - WAIT_W: hold address, data_in and write_enable while busy=1. On busy=0, write_enable<=0 -> RESP. A duplicate same-data write during a hit is harmless.
  - RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_error -> IDLE. resp_valid=0 in every other state.
- Timeout:
  - The counter clears on accept and increments each cycle in ISSUE/SETTLE/WAIT_R/WAIT_W.
  - When it reaches TIMEOUT_CYCLES (if nonzero): write_enable<=0, resp_error=1, resp_rdata=0 -> RESP.
- Latency: a load that hits in an idle cache gives resp_valid 4 cycles after the accept edge (ISSUE, SETTLE, WAIT_R, RESP). Misses extend WAIT_R/WAIT_W by the cache fill/evict time.
- address and data_in keep their last values in IDLE; write_enable is always 0 in IDLE.
- Requests arriving while not IDLE are not accepted; req_valid must be held by the source.

Test Plan:
- Preload RAM word@8=AB4C3E6F, @12=9D8E2F17, @16=D5B8A9C4, @32=2F5E3C7A.
- Load signed byte @11 (miss) -> address=8, write_enable=0, single resp_valid with resp_rdata=FFFFFFAB, resp_error=0; an immediately repeated load (hit) responds exactly 4 cycles after accept.
- Load unsigned byte @8 -> 0000006F. Load unsigned half @10 -> 0000AB4C. Load signed half @18 -> FFFFD5B8. Load word @32 -> 2F5E3C7A.
- Store byte 0x12 @9 -> write_enable=0010 and data_in=00001200 in the same cycle, write_enable back to 0 before resp_valid; then load word @8 -> AB4C126F.
- Load word @6, then store half @13 -> each gives resp_error=1 one cycle after accept; write_enable and address unchanged.
- Store word @64 with busy forced high for 2000 cycles, TIMEOUT_CYCLES=1024 -> resp_error=1 on cycle 1024; write_enable=0 afterwards.
- Drop rst_n during WAIT_W of a store miss -> write_enable=0 and resp_valid=0 immediately; req_ready=1 after rst_n rises.
